// File: rtl/fetch_if.sv
// Fetch-side bundle between the sequencer, the PC register, instruction memory
// and the hazard/branch logic.
interface fetch_if #(
  parameter int unsigned PC_W = 32
);
  logic [PC_W-1:0] pc;
  logic            pc_en;
  logic [PC_W-1:0] next_pc;
  logic            iren;
  logic            ihit;
  logic            stall;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            jump;
  logic [PC_W-1:0] jump_target;
  logic            halt;
  logic            fetch_valid;
  logic            redirect_pending;
  logic            halted;

  // Sequencer side
  modport master (
    input  pc, ihit, stall, br_taken, br_target, jump, jump_target, halt,
    output pc_en, next_pc, iren, fetch_valid, redirect_pending, halted
  );

  // Core / memory side
  modport slave (
    output pc, ihit, stall, br_taken, br_target, jump, jump_target, halt,
    input  pc_en, next_pc, iren, fetch_valid, redirect_pending, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC advance/redirect controller: sequences imem reads, holds blocked
// branch/jump redirects in a single slot, squashes wrong-path fetches, halts.
module fetch_sequencer #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic     CLK,
  input logic     RST,
  fetch_if.master bus
);

  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state;
  logic            slot_vld;
  logic            slot_br;
  logic [PC_W-1:0] slot_tgt;
  logic            iren_q;
  logic            halted_q;

  logic            advance;
  logic [PC_W-1:0] sel_pc;
  logic [PC_W-1:0] next_pc_c;

  assign advance = (state == FETCH) && bus.ihit && !bus.stall && !bus.halt;

  // Redirect priority: live branch, held branch, live jump, held jump, pc+4
  always_comb begin
    sel_pc = bus.pc + PC_STEP;
    if (bus.br_taken)            sel_pc = bus.br_target;
    else if (slot_vld && slot_br) sel_pc = slot_tgt;
    else if (bus.jump)           sel_pc = bus.jump_target;
    else if (slot_vld)           sel_pc = slot_tgt;
  end

  always_comb begin
    next_pc_c = sel_pc;
    case (state)
      BOOT:    next_pc_c = RESET_PC;
      HALTED:  next_pc_c = bus.pc;
      default: next_pc_c = sel_pc;
    endcase
  end

  assign bus.pc_en            = advance;
  assign bus.next_pc          = next_pc_c & ALIGN_MASK;
  assign bus.fetch_valid      = advance && !bus.br_taken && !bus.jump && !slot_vld;
  assign bus.iren             = iren_q;
  assign bus.redirect_pending = slot_vld;
  assign bus.halted           = halted_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= BOOT;
      slot_vld <= 1'b0;
      slot_br  <= 1'b0;
      slot_tgt <= '0;
      iren_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state  <= FETCH;
          iren_q <= 1'b1;
        end
        FETCH: begin
          // An advance edge applies whatever redirect was selected, so the slot empties
          if (advance) begin
            slot_vld <= 1'b0;
          end else if (bus.br_taken) begin
            slot_vld <= 1'b1;
            slot_br  <= 1'b1;
            slot_tgt <= bus.br_target;
          end else if (bus.jump && !(slot_vld && slot_br)) begin
            slot_vld <= 1'b1;
            slot_br  <= 1'b0;
            slot_tgt <= bus.jump_target;
          end
          if (bus.halt) begin
            state    <= HALTED;
            iren_q   <= 1'b0;
            halted_q <= 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer against a
// transaction-level model of the redirect slot and PC register.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam int          PH_BOOT  = 0;
  localparam int          PH_FETCH = 1;
  localparam int          PH_HALT  = 2;

  logic CLK;
  logic RST;

  fetch_if #(.PC_W(32)) bus ();

  fetch_sequencer #(.PC_W(32), .RESET_PC(RST_PC)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errs   = 0;

  // stimulus copies
  logic        s_ihit, s_stall, s_br, s_j, s_halt;
  logic [31:0] s_brt, s_jt;

  // model state
  int          m_phase;
  logic [31:0] m_pc;
  logic        m_pv, m_pbr;
  logic [31:0] m_ptgt;

  // model expectations for the current cycle
  logic        e_en, e_fv;
  logic [31:0] e_np;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ihit, input logic stall, input logic br, input logic [31:0] brt,
                       input logic j, input logic [31:0] jt, input logic halt);
    s_ihit = ihit; s_stall = stall; s_br = br; s_brt = brt; s_j = j; s_jt = jt; s_halt = halt;
    bus.pc          = m_pc;
    bus.ihit        = ihit;
    bus.stall       = stall;
    bus.br_taken    = br;
    bus.br_target   = brt;
    bus.jump        = j;
    bus.jump_target = jt;
    bus.halt        = halt;
    #1;
  endtask

  task automatic idle(input logic ihit);
    drive(ihit, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] exp_next();
    logic [31:0] v;
    if (m_phase == PH_BOOT)      v = RST_PC;
    else if (m_phase == PH_HALT) v = m_pc;
    else if (s_br)               v = s_brt;
    else if (m_pv && m_pbr)      v = m_ptgt;
    else if (s_j)                v = s_jt;
    else if (m_pv)               v = m_ptgt;
    else                         v = m_pc + 32'd4;
    return v & 32'hFFFF_FFFC;
  endfunction

  task automatic check_model(input string tag);
    e_en = (m_phase == PH_FETCH) && s_ihit && !s_stall && !s_halt;
    e_fv = e_en && !s_br && !s_j && !m_pv;
    e_np = exp_next();
    chk({tag, ".pc_en"},   32'(bus.pc_en),            32'(e_en));
    chk({tag, ".next_pc"}, bus.next_pc,               e_np);
    chk({tag, ".fvalid"},  32'(bus.fetch_valid),      32'(e_fv));
    chk({tag, ".iren"},    32'(bus.iren),             32'(m_phase == PH_FETCH));
    chk({tag, ".halted"},  32'(bus.halted),           32'(m_phase == PH_HALT));
    chk({tag, ".pending"}, 32'(bus.redirect_pending), 32'(m_pv));
  endtask

  task automatic model_update();
    case (m_phase)
      PH_BOOT: m_phase = PH_FETCH;
      PH_FETCH: begin
        if (e_en) begin
          m_pv = 1'b0;
          m_pc = e_np;
        end else if (s_br) begin
          m_pv = 1'b1; m_pbr = 1'b1; m_ptgt = s_brt;
        end else if (s_j && !(m_pv && m_pbr)) begin
          m_pv = 1'b1; m_pbr = 1'b0; m_ptgt = s_jt;
        end
        if (s_halt) m_phase = PH_HALT;
      end
      default: ;
    endcase
  endtask

  task automatic step(input string tag);
    check_model(tag);
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  // Asynchronous reset asserted mid-cycle, released on the next falling edge
  task automatic do_reset(input string tag);
    #1;
    RST = 1'b1;
    m_phase = PH_BOOT; m_pv = 1'b0; m_pbr = 1'b0; m_pc = RST_PC;
    bus.pc = m_pc;
    #1;
    chk({tag, ".rst_next_pc"}, bus.next_pc, RST_PC);
    check_model(tag);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    m_phase = PH_BOOT; m_pv = 1'b0; m_pbr = 1'b0; m_ptgt = '0; m_pc = RST_PC;
    idle(1'b0);
    repeat (2) @(negedge CLK);
    check_model("por");
    RST = 1'b0;

    // 1: boot, build a pending branch, reset mid-fetch, boot again
    idle(1'b1);
    chk("t1.boot_iren", 32'(bus.iren), 32'h0);
    step("t1.boot");
    idle(1'b1);
    chk("t1.first_np", bus.next_pc, 32'h4);
    step("t1.f0");
    drive(1'b0, 1'b0, 1'b1, 32'h123, 1'b0, 32'h0, 1'b0);
    step("t1.blk");
    idle(1'b1);
    chk("t1.pend_before_rst", 32'(bus.redirect_pending), 32'h1);
    do_reset("t1.rst");
    chk("t1.rst_pending", 32'(bus.redirect_pending), 32'h0);
    idle(1'b1);
    chk("t1.boot2_iren", 32'(bus.iren), 32'h0);
    step("t1.boot2");
    idle(1'b1);
    chk("t1.after_boot_np", bus.next_pc, RST_PC + 32'h4);
    chk("t1.after_boot_en", 32'(bus.pc_en), 32'h1);
    step("t1.f1");

    // 2: sequential fetch and wrap
    m_pc = 32'h40;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("t2.seq_np", bus.next_pc, 32'h44 + 32'(4 * i));
      chk("t2.seq_fv", 32'(bus.fetch_valid), 32'h1);
      step("t2.seq");
    end
    m_pc = 32'hFFFF_FFFC;
    idle(1'b1);
    chk("t2.wrap_np", bus.next_pc, 32'h0);
    step("t2.wrap");

    // 3: branch blocked by a miss, applied on the hit
    m_pc = 32'h100;
    drive(1'b0, 1'b0, 1'b1, 32'h203, 1'b0, 32'h0, 1'b0);
    step("t3.br");
    idle(1'b0);
    chk("t3.pending", 32'(bus.redirect_pending), 32'h1);
    chk("t3.no_en", 32'(bus.pc_en), 32'h0);
    step("t3.wait");
    idle(1'b1);
    chk("t3.apply_np", bus.next_pc, 32'h200);
    chk("t3.apply_en", 32'(bus.pc_en), 32'h1);
    chk("t3.apply_fv", 32'(bus.fetch_valid), 32'h0);
    step("t3.apply");
    idle(1'b0);
    chk("t3.cleared", 32'(bus.redirect_pending), 32'h0);
    step("t3.idle");

    // 4: slot overwrite rules under stall
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
    step("t4.j");
    drive(1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
    step("t4.b");
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("t4.br_over_j", bus.next_pc, 32'h500);
    step("t4.rel1");
    drive(1'b1, 1'b1, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0);
    step("t4.b2");
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h700, 1'b0);
    step("t4.j2");
    idle(1'b1);
    chk("t4.br_kept", bus.next_pc, 32'h600);
    step("t4.rel2");

    // 5: simultaneous branch and jump while advancing
    drive(1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h90, 1'b0);
    chk("t5.np", bus.next_pc, 32'h80);
    chk("t5.fv", 32'(bus.fetch_valid), 32'h0);
    step("t5.both");
    idle(1'b0);
    chk("t5.no_pend", 32'(bus.redirect_pending), 32'h0);
    step("t5.idle");

    // 6: halt, ignored redirect, reset exit
    m_pc = 32'h20;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("t6.halt_en", 32'(bus.pc_en), 32'h0);
    step("t6.halt");
    drive(1'b1, 1'b0, 1'b1, 32'h44, 1'b0, 32'h0, 1'b0);
    chk("t6.halted", 32'(bus.halted), 32'h1);
    chk("t6.iren", 32'(bus.iren), 32'h0);
    chk("t6.br_no_en", 32'(bus.pc_en), 32'h0);
    chk("t6.hold_np", bus.next_pc, 32'h20);
    step("t6.hbr");
    idle(1'b1);
    step("t6.still");
    do_reset("t6.rst");
    chk("t6.unhalted", 32'(bus.halted), 32'h0);
    idle(1'b1);
    step("t6.boot");

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if (m_phase == PH_HALT && $urandom_range(0, 5) == 0) begin
        idle(1'b0);
        do_reset("rnd.rst");
      end
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
            $urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 149) == 0);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
